counter_ctrl: RTL and testbench
===============================

# counter_ctrl

Command-driven sequencer for the 8-bit up/down counter. It drives the counter's `enable` and `direction` inputs and reads back `counter_out`. It accepts GOTO, SWEEP and STOP commands over a valid/ready handshake. It sits between a host/register interface and the counter, and it reports completion, stalls and illegal commands.

## Interface
- `WIDTH`, default 8: counter width; `lo`/`hi`/`target`/`turns` are all this width.
- `STALL_LIMIT`, default 2: consecutive enabled cycles with no count change before a stall error.
- `clk`  in  1: rising-edge clock, shared with the counter.
- `rst`  in  1: asynchronous reset, active-low.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: command accepted on an edge where `cmd_valid && cmd_ready`.
- `cmd_op`  in  2: 00 GOTO, 01 SWEEP, 10 STOP, 11 reserved.
- `cmd_a`  in  WIDTH: GOTO target; SWEEP `lo`.
- `cmd_b`  in  WIDTH: SWEEP `hi`; ignored otherwise.
- `counter_out`  in  WIDTH: current counter value.
- `enable`  out  1: to counter; count changes on the next edge when high.
- `direction`  out  1: to counter; 1 = +1, 0 = −1.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse when a GOTO completes.
- `err`  out  1: one-cycle pulse on an illegal command or a stall.
- `turns`  out  WIDTH: count of sweep reversals; wraps 255→0.

## Operation
- States: IDLE, SEEK, SWEEP. A `sweep_pending` flag marks that SEEK is a lead-in to SWEEP. An `up` flag gives the sweep direction.
- `enable` and `direction` are combinational from the state and `counter_out`. This prevents overshoot.
- IDLE:
  - `enable`=0, `cmd_ready`=1.
  - GOTO → SEEK with `target`=`cmd_a`, `sweep_pending`=0.
  - SWEEP with `cmd_a` < `cmd_b` → SEEK with `target`=`lo`, `sweep_pending`=1; also `up`=1, `turns`=0.
  - SWEEP with `cmd_a` ≥ `cmd_b` → `err` pulse, stay in IDLE.
  - STOP → no-op.
  - op 11 → `err` pulse.
- SEEK:
  - `cmd_ready`=0.
  - `enable` = (`counter_out` != `target`); `direction` = (`target` > `counter_out`). Unsigned compare, no wrap path.
  - On `counter_out`==`target`: if `sweep_pending`, go to SWEEP; else go to IDLE and pulse `done`.
- SWEEP:
  - `cmd_ready`=1, `enable`=1.
  - `direction` = `up` ? (`counter_out` != `hi`) : (`counter_out` == `lo`).
  - At `up` && `counter_out`==`hi`: clear `up`, increment `turns`.
  - At !`up` && `counter_out`==`lo`: set `up`, increment `turns`.
  - Result: triangle wave lo→hi→lo.
  - STOP → IDLE; the counter holds its current value.
  - GOTO or a legal SWEEP aborts the sweep and is handled as in IDLE.
  - An illegal SWEEP pulses `err` and the sweep continues.
- Stall detect:
  - Applies in SEEK and SWEEP.
  - The error fires when `enable` was high and the registered previous `counter_out` equals the current value for `STALL_LIMIT` consecutive cycles.
  - Response: `err` pulse, go to IDLE, `done` not asserted.
- `turns` holds its value after STOP. It is cleared only by reset or by the start of a new SWEEP.

## Timing
- Reset values: state IDLE, `enable`=0, `direction`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `turns`=0, `up`=1, `sweep_pending`=0.
- Asserting `rst` mid-operation returns all outputs to these values immediately.
- GOTO accepted at edge E0 with distance d = |`target` − count`:
  - `enable` is high for d cycles after E0.
  - The counter reaches `target` at edge E0+d.
  - State returns to IDLE at E0+d+1, and `done` is high for the cycle after it.
  - GOTO to the current value: `done` is high for the cycle after E0+1.
- `err` is registered: it is high for the cycle after the accepting or detecting edge.
- Sweep period = 2·(hi−lo) cycles; each endpoint appears for one cycle.
- An external counter reset to 0 is a count change, not a stall. SEEK re-converges from 0.

## Test plan
- Reset, then GOTO 5 from count 0:
  - `enable`=1, `direction`=1 for 5 cycles, then count=5.
  - `done` pulses once, 7 cycles after accept.
  - `busy` falls with `done`.
- From count 9, GOTO 3: `direction`=0 for 6 cycles, count=3, `done` pulse, no `err`.
- SWEEP lo=2, hi=4 from count 0:
  - Count sequence after the lead-in is 2,3,4,3,2,3,4…
  - `turns`=4 after two full periods.
  - STOP freezes the count; `turns` is held.
- SWEEP lo=6, hi=6:
  - `err` pulses one cycle; state stays IDLE; count unchanged.
  - Repeat with op 11: same response.
- Hold the counter's `enable` path broken (count frozen at 7) during GOTO 10: `err` pulses after 2 stalled cycles, state goes IDLE, no `done`.
- Assert `rst` low mid-SWEEP: `enable`=0, `busy`=0 and `turns`=0 immediately; a GOTO after release works normally.

Source files
------------

// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven sequencer for an up/down counter.
//
// Accepts GOTO, SWEEP and STOP commands over a valid/ready handshake and
// drives the counter's enable/direction so that it seeks a target value or
// sweeps a triangle wave between lo and hi. It reports GOTO completion (done),
// and illegal commands or a stalled counter (err).
//
// Ports
//   clk          rising-edge clock, shared with the counter
//   rst          asynchronous reset, active-low
//   cmd_valid    command present
//   cmd_ready    command accepted on an edge with cmd_valid && cmd_ready
//   cmd_op       00 GOTO, 01 SWEEP, 10 STOP, 11 reserved
//   cmd_a        GOTO target / SWEEP lo
//   cmd_b        SWEEP hi
//   counter_out  current counter value
//   enable       counter enable (count changes on the next edge when high)
//   direction    1 = count up, 0 = count down
//   busy         sequencer not idle
//   done         one-cycle pulse when a GOTO completes
//   err          one-cycle pulse on an illegal command or a stall
//   turns        number of sweep reversals (wraps)
module counter_ctrl #(
    parameter int WIDTH       = 8,
    parameter int STALL_LIMIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [WIDTH-1:0] counter_out,
    output logic             enable,
    output logic             direction,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] turns
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEEK  = 2'd1,
        S_SWEEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_GOTO  = 2'b00;
    localparam logic [1:0] OP_SWEEP = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;

    localparam int              SC_W       = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_LIMIT - 1);

    state_t            state, state_nxt;
    logic              sweep_pending, sweep_pending_nxt;
    logic              up, up_nxt;
    logic [WIDTH-1:0]  turns_nxt;
    logic              done_nxt, err_nxt;
    logic [SC_W-1:0]   stall_cnt, stall_cnt_nxt;
    logic              ld_target, ld_range;

    logic [WIDTH-1:0]  target, lo, hi;
    logic [WIDTH-1:0]  cnt_p1;
    logic              en_p1;

    logic              cmd_fire;
    logic              stall_seen;
    logic              stall_err;

    assign busy     = (state != S_IDLE);
    assign cmd_fire = cmd_valid && cmd_ready;

    // A stalled cycle is one where the counter was enabled on the previous
    // edge yet shows the same value; an external clear to 0 counts as a change.
    assign stall_seen = busy && en_p1 && (cnt_p1 == counter_out);
    assign stall_err  = stall_seen && (stall_cnt == STALL_LAST);

    always_comb begin
        state_nxt         = state;
        sweep_pending_nxt = sweep_pending;
        up_nxt            = up;
        turns_nxt         = turns;
        done_nxt          = 1'b0;
        err_nxt           = 1'b0;
        ld_target         = 1'b0;
        ld_range          = 1'b0;
        enable            = 1'b0;
        direction         = 1'b0;
        cmd_ready         = 1'b0;

        case (state)
            S_SEEK: begin
                enable    = (counter_out != target);
                direction = (target > counter_out);
                if (counter_out == target) begin
                    if (sweep_pending) begin
                        state_nxt = S_SWEEP;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                cmd_ready = 1'b1;
                enable    = 1'b1;
                direction = up ? (counter_out != hi) : (counter_out == lo);
                if (up && (counter_out == hi)) begin
                    up_nxt    = 1'b0;
                    turns_nxt = turns + WIDTH'(1);
                end else if (!up && (counter_out == lo)) begin
                    up_nxt    = 1'b1;
                    turns_nxt = turns + WIDTH'(1);
                end
            end
            default: begin
                cmd_ready = 1'b1;
            end
        endcase

        // Commands are only accepted in IDLE and SWEEP; a new GOTO or legal
        // SWEEP aborts a running sweep, an illegal one leaves it running.
        if (cmd_fire) begin
            case (cmd_op)
                OP_GOTO: begin
                    state_nxt         = S_SEEK;
                    sweep_pending_nxt = 1'b0;
                    ld_target         = 1'b1;
                end
                OP_SWEEP: begin
                    if (cmd_a < cmd_b) begin
                        state_nxt         = S_SEEK;
                        sweep_pending_nxt = 1'b1;
                        up_nxt            = 1'b1;
                        turns_nxt         = '0;
                        ld_target         = 1'b1;
                        ld_range          = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                OP_STOP: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    err_nxt = 1'b1;
                end
            endcase
        end

        if (stall_err) begin
            state_nxt         = S_IDLE;
            sweep_pending_nxt = 1'b0;
            done_nxt          = 1'b0;
            err_nxt           = 1'b1;
        end

        stall_cnt_nxt = (stall_seen && !stall_err) ? stall_cnt + SC_W'(1) : '0;
    end

    // Control state: state, flags, pulses, reversal count, stall tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            sweep_pending <= 1'b0;
            up            <= 1'b1;
            turns         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            stall_cnt     <= '0;
            en_p1         <= 1'b0;
        end else begin
            state         <= state_nxt;
            sweep_pending <= sweep_pending_nxt;
            up            <= up_nxt;
            turns         <= turns_nxt;
            done          <= done_nxt;
            err           <= err_nxt;
            stall_cnt     <= stall_cnt_nxt;
            en_p1         <= enable;
        end
    end

    // Data: command operands and previous counter sample
    always_ff @(posedge clk) begin
        cnt_p1 <= counter_out;
        if (ld_target) begin
            target <= cmd_a;
        end
        if (ld_range) begin
            lo <= cmd_a;
            hi <= cmd_b;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic       enable, direction, busy, done, err;
    logic [7:0] turns;

    // Counter being sequenced, with hooks to freeze it or clear it externally
    logic [7:0] cnt     = 8'd0;
    logic       frozen  = 1'b0;
    logic       ext_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    localparam int STALL_LIMIT = 2;

    counter_ctrl #(.WIDTH(8), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .counter_out(cnt),
        .enable     (enable),
        .direction  (direction),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .turns      (turns)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ext_clr)
            cnt <= 8'd0;
        else if (enable && !frozen)
            cnt <= direction ? cnt + 8'd1 : cnt - 8'd1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge; the following rising edge accepts the command.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        check("cmd_ready_at_send", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Reference: GOTO moves one step per cycle for |t-c| cycles, then the
    // sequencer idles one cycle later with a single done pulse.
    task automatic run_goto(input int t);
        int c0 = int'(cnt);
        int d  = (t > c0) ? t - c0 : c0 - t;
        send(2'b00, 8'(t), 8'd0);
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            check("goto_enable", enable, 1);
            check("goto_direction", direction, (t > c0) ? 1 : 0);
            check("goto_busy", busy, 1);
            if (k == 0) check("goto_ready_low", cmd_ready, 0);
        end
        @(negedge clk);
        check("goto_count", cnt, t);
        check("goto_enable_off", enable, 0);
        check("goto_done_early", done, 0);
        check("goto_busy_hold", busy, 1);
        @(negedge clk);
        check("goto_done", done, 1);
        check("goto_busy_fall", busy, 0);
        check("goto_no_err", err, 0);
        @(negedge clk);
        check("goto_done_single", done, 0);
        check("goto_count_held", cnt, t);
    endtask

    // Reference: after the lead-in, sweep position j shows lo + triangle(j)
    // with period 2p (p = hi-lo); a reversal happens on leaving every
    // position j > 0 that is a multiple of p.
    task automatic run_sweep(input int lo, input int hi, input int n);
        int c0 = int'(cnt);
        int d  = (lo > c0) ? lo - c0 : c0 - lo;
        int p  = hi - lo;
        int m, pos_n, exp_turns;
        send(2'b01, 8'(lo), 8'(hi));
        for (int k = 0; k < d; k++) begin
            @(negedge clk);
            check("lead_enable", enable, 1);
            check("lead_direction", direction, (lo > c0) ? 1 : 0);
            check("lead_turns", turns, 0);
        end
        @(negedge clk);
        check("lead_count", cnt, lo);
        check("lead_enable_off", enable, 0);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            m = j % (2 * p);
            check("sweep_count", cnt, lo + ((m <= p) ? m : 2 * p - m));
            check("sweep_direction", direction, (m < p) ? 1 : 0);
            check("sweep_enable", enable, 1);
            check("sweep_turns", turns, (j == 0) ? 0 : ((j - 1) / p) % 256);
        end
        send(2'b10, 8'd0, 8'd0);
        m         = n % (2 * p);
        pos_n     = lo + ((m <= p) ? m : 2 * p - m);
        exp_turns = ((n - 1) / p) % 256;
        @(negedge clk);
        check("stop_busy", busy, 0);
        check("stop_enable", enable, 0);
        check("stop_count", cnt, pos_n);
        check("stop_turns", turns, exp_turns);
        @(negedge clk);
        check("stop_count_held", cnt, pos_n);
        check("stop_turns_held", turns, exp_turns);
    endtask

    task automatic run_illegal(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int c0 = int'(cnt);
        send(op, a, b);
        @(negedge clk);
        check("illegal_err", err, 1);
        check("illegal_busy", busy, 0);
        check("illegal_enable", enable, 0);
        check("illegal_count", cnt, c0);
        @(negedge clk);
        check("illegal_err_single", err, 0);
        check("illegal_count_held", cnt, c0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got_done, saw_err;

        // Reset values
        @(negedge clk);
        check("rst_enable", enable, 0);
        check("rst_direction", direction, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_turns", turns, 0);
        rst = 1'b1;
        @(negedge clk);

        run_goto(5);
        run_goto(9);
        run_goto(3);
        run_goto(3);

        run_sweep(2, 4, 9);
        check("sweep_two_periods_turns", turns, 4);

        run_illegal(2'b01, 8'd6, 8'd6);
        run_illegal(2'b11, 8'd6, 8'd6);
        run_illegal(2'b01, 8'd9, 8'd2);

        // STOP while idle does nothing
        send(2'b10, 8'd0, 8'd0);
        @(negedge clk);
        check("idle_stop_busy", busy, 0);
        check("idle_stop_err", err, 0);

        // Frozen counter: stall error, no done
        run_goto(7);
        frozen = 1'b1;
        send(2'b00, 8'd10, 8'd0);
        for (int k = 0; k <= STALL_LIMIT; k++) begin
            @(negedge clk);
            check("stall_err_early", err, 0);
            check("stall_busy", busy, 1);
        end
        @(negedge clk);
        check("stall_err", err, 1);
        check("stall_busy_fall", busy, 0);
        check("stall_no_done", done, 0);
        check("stall_enable", enable, 0);
        check("stall_count", cnt, 7);
        @(negedge clk);
        check("stall_err_single", err, 0);
        check("stall_no_done_late", done, 0);
        frozen = 1'b0;

        // External clear to 0 mid-seek: re-converges without a stall
        run_goto(10);
        send(2'b00, 8'd30, 8'd0);
        repeat (3) @(negedge clk);
        ext_clr = 1'b1;
        @(posedge clk);
        #1 ext_clr = 1'b0;
        got_done = 0;
        saw_err  = 0;
        for (int k = 0; k < 100 && got_done == 0; k++) begin
            @(negedge clk);
            if (err) saw_err = 1;
            if (done) got_done = 1;
        end
        check("extclr_done", got_done, 1);
        check("extclr_no_err", saw_err, 0);
        check("extclr_count", cnt, 30);
        @(negedge clk);

        // Reset asserted mid-sweep
        send(2'b01, 8'd20, 8'd23);
        repeat (25) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_enable", enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_turns", turns, 0);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_direction", direction, 0);
        @(negedge clk);
        rst = 1'b1;
        run_goto(int'(cnt) + 4);

        // Randomized commands
        for (int it = 0; it < 14; it++) begin
            int sel, lo, hi, a;
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                run_goto($urandom_range(0, 60));
            end else if (sel == 1) begin
                lo = $urandom_range(0, 40);
                hi = lo + $urandom_range(1, 6);
                run_sweep(lo, hi, $urandom_range(1, 20));
            end else begin
                a = $urandom_range(0, 255);
                run_illegal(2'b01, 8'(a), 8'($urandom_range(0, a)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
